mult_share_arbiter: RTL and testbench

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_if.sv | 35 +++
 rtl/mult_share_arbiter.sv | 130 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_if.sv
// Bundle of requester, shared-multiplier and response signals around mult_share_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mult_share_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ*DATA_WIDTH-1:0] req_a;
  logic [NREQ*DATA_WIDTH-1:0] req_b;
  logic [NREQ-1:0]            req_carry;

  logic [DATA_WIDTH-1:0]      mul_a;
  logic [DATA_WIDTH-1:0]      mul_b;
  logic                       mul_carry_option;
  logic [2*DATA_WIDTH-1:0]    mul_out;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [2*DATA_WIDTH-1:0]    rsp_data;
  logic [IDW-1:0]             rsp_id;
  logic                       busy;

  modport slave (
    input  req_valid, req_a, req_b, req_carry, mul_out, rsp_ready,
    output req_ready, mul_a, mul_b, mul_carry_option, rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_carry, mul_out, rsp_ready,
    input  req_ready, mul_a, mul_b, mul_carry_option, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational multiplier
// among NREQ requesters, one operation in flight at a time.
module mult_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 4,
  parameter int MUL_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_share_if.slave bus
);
  localparam int IDW   = $clog2(NREQ);
  localparam int CNT_W = 4;
  localparam int PW    = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        win_idx;
  logic                  win_found;
  logic                  accept;
  logic [NREQ-1:0]       grant_vec;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic                  sel_carry;
  logic [DATA_WIDTH-1:0] mul_a_q, mul_b_q;
  logic                  mul_carry_q;
  logic                  rsp_valid_q;
  logic [PW-1:0]         rsp_data_q;
  logic [IDW-1:0]        rsp_id_q;

  // Returns {found, index}: first valid requester at or above ptr, wrapping.
  function automatic logic [IDW:0] pick_winner(input logic [NREQ-1:0] vld,
                                               input logic [IDW-1:0]  ptr);
    logic [IDW:0]   res;
    logic [IDW-1:0] jj;
    int             j;
    res = '0;
    for (int k = 0; k < NREQ; k++) begin
      j  = (int'(ptr) + k) % NREQ;
      jj = IDW'(j);
      if (!res[IDW] && vld[jj]) res = {1'b1, jj};
    end
    return res;
  endfunction

  assign {win_found, win_idx} = pick_winner(bus.req_valid, rr_ptr);
  assign accept    = (state == IDLE) && win_found;
  assign grant_vec = accept ? (NREQ'(1) << win_idx) : '0;

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_carry = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_a     = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b     = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
        sel_carry = bus.req_carry[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)           state_nxt = CALC;
      CALC:    if (cnt == '0)        state_nxt = RESP;
      RESP:    if (bus.rsp_ready)    state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Accept stage: operands latched once and held for the whole CALC window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      cnt         <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_carry_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      if (accept) begin
        mul_a_q     <= sel_a;
        mul_b_q     <= sel_b;
        mul_carry_q <= sel_carry;
        rsp_id_q    <= win_idx;
        rr_ptr      <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        cnt         <= CNT_W'(MUL_LAT - 1);
      end else if (state == CALC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Response stage: product sampled once the settle budget is spent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (state == CALC && cnt == '0) begin
        rsp_data_q  <= bus.mul_out;
        rsp_valid_q <= 1'b1;
      end else if (state == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready        = grant_vec;
  assign bus.mul_a            = mul_a_q;
  assign bus.mul_b            = mul_b_q;
  assign bus.mul_carry_option = mul_carry_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.rsp_id           = rsp_id_q;
  assign bus.busy             = (state != IDLE);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: one instance with MUL_LAT=1 and one
// with MUL_LAT=3 whose multiplier model outputs garbage until it has settled.
`timescale 1ns/1ps
module tb_mult_share_arbiter;
  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_share_if #(.DATA_WIDTH(DW), .NREQ(NR)) bus1();
  mult_share_if #(.DATA_WIDTH(DW), .NREQ(NR)) bus3();

  mult_share_arbiter #(.DATA_WIDTH(DW), .NREQ(NR), .MUL_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  mult_share_arbiter #(.DATA_WIDTH(DW), .NREQ(NR), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  function automatic logic [63:0] clmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (b[i]) r = r ^ (64'(a) << i);
    return r;
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
    return c ? (64'(a) * 64'(b)) : clmul(a, b);
  endfunction

  assign bus1.mul_out = ref_mul(bus1.mul_a, bus1.mul_b, bus1.mul_carry_option);

  logic [63:0] p3_now, p3_d1, p3_d2;
  assign p3_now = ref_mul(bus3.mul_a, bus3.mul_b, bus3.mul_carry_option);
  always @(posedge clk) begin
    p3_d1 <= p3_now;
    p3_d2 <= p3_d1;
  end
  assign bus3.mul_out = (p3_d2 === p3_now) ? p3_now : 64'hBAD0_BAD0_BAD0_BAD0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    data;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_carry = '0;
    bus1.rsp_ready = 1'b0;
    bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_carry = '0;
    bus3.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int sel, input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
    if (sel == 1) begin
      bus1.req_a[i*DW +: DW] = a; bus1.req_b[i*DW +: DW] = b;
      bus1.req_carry[i] = c; bus1.req_valid[i] = 1'b1;
    end else begin
      bus3.req_a[i*DW +: DW] = a; bus3.req_b[i*DW +: DW] = b;
      bus3.req_carry[i] = c; bus3.req_valid[i] = 1'b1;
    end
  endtask

  task automatic push_exp(input int id, input logic [63:0] data);
    exp_t e;
    e.id   = IDW'(id);
    e.data = data;
    sb.push_back(e);
  endtask

  // Bounded wait for rsp_valid; the caller turns a timeout into a failed check.
  task automatic wait_rsp(input int sel, input int max_cyc, output bit ok);
    int cyc;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < max_cyc) begin
      if ((sel == 1 ? bus1.rsp_valid : bus3.rsp_valid) === 1'b1) ok = 1'b1;
      else begin tick(); cyc++; end
    end
  endtask

  task automatic test_reset();
    logic [136:0] got1, got3;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    got1 = {bus1.busy, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_id, bus1.mul_a, bus1.mul_b,
            bus1.mul_carry_option, bus1.req_ready};
    got3 = {bus3.busy, bus3.rsp_valid, bus3.rsp_data, bus3.rsp_id, bus3.mul_a, bus3.mul_b,
            bus3.mul_carry_option, bus3.req_ready};
    n_checks++;
    if (got1 !== '0) $display("FAIL reset_outputs_lat1: got %h expected 0", got1);
    else n_pass++;
    n_checks++;
    if (got3 !== '0) $display("FAIL reset_outputs_lat3: got %h expected 0", got3);
    else n_pass++;
    bus1.req_valid = 4'b0110;
    #1;
    n_checks++;
    if (bus1.req_ready !== 4'b0010)
      $display("FAIL reset_req_ready: got %b expected 0010", bus1.req_ready);
    else n_pass++;
    bus1.req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({bus1.busy, bus1.rsp_valid, bus1.req_ready} !== 6'b0)
      $display("FAIL reset_release_idle: got %b expected 000000",
               {bus1.busy, bus1.rsp_valid, bus1.req_ready});
    else n_pass++;
  endtask

  task automatic test_single();
    bit   ok;
    logic c;
    exp_t e;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      c = (pass == 1);
      set_req(1, 2, 32'd3, 32'd3, c);
      push_exp(2, c ? 64'd9 : 64'd5);
      #1;
      n_checks++;
      if (bus1.req_ready !== 4'b0100)
        $display("FAIL single_grant[%0d]: got %b expected 0100", pass, bus1.req_ready);
      else n_pass++;
      tick();
      bus1.req_valid = '0;
      #1;
      n_checks++;
      if ({bus1.busy, bus1.rsp_valid, bus1.req_ready} !== 6'b100000)
        $display("FAIL single_calc[%0d]: got %b expected 100000", pass,
                 {bus1.busy, bus1.rsp_valid, bus1.req_ready});
      else n_pass++;
      tick();
      n_checks++;
      if (bus1.rsp_valid !== 1'b1)
        $display("FAIL single_latency[%0d]: rsp_valid %b expected 1", pass, bus1.rsp_valid);
      else n_pass++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({bus1.rsp_id, bus1.rsp_data} !== {e.id, e.data})
          $display("FAIL single_rsp[%0d]: got id %0d data %h expected id %0d data %h", pass,
                   bus1.rsp_id, bus1.rsp_data, e.id, e.data);
        else n_pass++;
      end
      bus1.rsp_ready = 1'b1;
      tick();
      bus1.rsp_ready = 1'b0;
      n_checks++;
      if ({bus1.busy, bus1.rsp_valid} !== 2'b00)
        $display("FAIL single_ack[%0d]: busy/valid %b expected 00", pass,
                 {bus1.busy, bus1.rsp_valid});
      else n_pass++;
      wait_rsp(1, 1, ok);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] a[NR], b[NR];
    logic        c[NR];
    int          grants, last, cyc, exp_id;
    bit          ok;
    exp_t        e;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      a[i] = 32'h0001_0003 + 32'(i) * 32'h0011_1111;
      b[i] = 32'h0000_0105 + 32'(i) * 32'h0000_0E21;
      c[i] = (i % 2 == 0);
      set_req(1, i, a[i], b[i], c[i]);
    end
    for (int g = 0; g < 5; g++) push_exp(g % NR, ref_mul(a[g % NR], b[g % NR], c[g % NR]));
    bus1.rsp_ready = 1'b1;
    #1;
    grants = 0; last = 0; cyc = 0;
    while (grants < 5 && cyc < 40) begin
      if (bus1.req_ready !== 4'b0000) begin
        exp_id = grants % NR;
        n_checks++;
        if (bus1.req_ready !== (4'b0001 << exp_id))
          $display("FAIL rr_order[%0d]: got %b expected %b", grants, bus1.req_ready,
                   4'b0001 << exp_id);
        else n_pass++;
        if (grants > 0) begin
          n_checks++;
          if (cyc - last !== 3)
            $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", grants, cyc - last);
          else n_pass++;
        end
        last = cyc;
        grants++;
      end
      if (bus1.rsp_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({bus1.rsp_id, bus1.rsp_data} !== {e.id, e.data})
          $display("FAIL rr_rsp: got id %0d data %h expected id %0d data %h",
                   bus1.rsp_id, bus1.rsp_data, e.id, e.data);
        else n_pass++;
      end
      tick();
      cyc++;
    end
    bus1.req_valid = '0;
    n_checks++;
    if (grants !== 5) $display("FAIL rr_grant_count: got %0d expected 5", grants);
    else n_pass++;
    wait_rsp(1, 10, ok);
    n_checks++;
    if (!ok || sb.size() != 1)
      $display("FAIL rr_last_rsp: got valid=%0d pending=%0d expected valid=1 pending=1",
               ok, sb.size());
    else begin
      e = sb.pop_front();
      if ({bus1.rsp_id, bus1.rsp_data} !== {e.id, e.data})
        $display("FAIL rr_last_rsp: got id %0d data %h expected id %0d data %h",
                 bus1.rsp_id, bus1.rsp_data, e.id, e.data);
      else n_pass++;
    end
    tick();
    bus1.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit   ok;
    exp_t e;
    do_reset();
    set_req(1, 1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    push_exp(1, 64'h0000_0001_FFFF_FFFE);
    tick();
    bus1.req_valid = '0;
    wait_rsp(1, 5, ok);
    n_checks++;
    if (!ok) $display("FAIL bp_rsp_timeout: rsp_valid 0 expected 1");
    else n_pass++;
    bus1.req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_checks++;
      if ({bus1.rsp_valid, bus1.rsp_data, bus1.rsp_id, bus1.busy, bus1.req_ready} !==
          {1'b1, 64'h0000_0001_FFFF_FFFE, 2'd1, 1'b1, 4'b0000})
        $display("FAIL bp_hold[%0d]: valid %b data %h id %0d busy %b ready %b expected 1 1fffffffe 1 1 0000",
                 k, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_id, bus1.busy, bus1.req_ready);
      else n_pass++;
      tick();
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({bus1.rsp_id, bus1.rsp_data} !== {e.id, e.data})
        $display("FAIL bp_rsp: got id %0d data %h expected id %0d data %h",
                 bus1.rsp_id, bus1.rsp_data, e.id, e.data);
      else n_pass++;
    end
    bus1.rsp_ready = 1'b1;
    tick();
    bus1.rsp_ready = 1'b0;
    n_checks++;
    if ({bus1.rsp_valid, bus1.busy, bus1.req_ready} !== 6'b000100)
      $display("FAIL bp_after_ack: valid/busy/ready %b expected 000100",
               {bus1.rsp_valid, bus1.busy, bus1.req_ready});
    else n_pass++;
    bus1.req_valid = '0;
  endtask

  task automatic test_latency3();
    exp_t e;
    do_reset();
    set_req(3, 0, 32'h0000_1234, 32'h0000_0055, 1'b1);
    push_exp(0, 64'h0000_0000_0006_0B44);
    #1;
    n_checks++;
    if (bus3.req_ready !== 4'b0001)
      $display("FAIL lat3_grant: got %b expected 0001", bus3.req_ready);
    else n_pass++;
    tick();
    bus3.req_valid = '0;
    bus3.req_a[31:0] = 32'hFFFF_0000;
    bus3.req_b[31:0] = 32'h0000_FFFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if ({bus3.rsp_valid, bus3.mul_a, bus3.mul_b} !== {1'b0, 32'h0000_1234, 32'h0000_0055})
        $display("FAIL lat3_calc[%0d]: valid %b a %h b %h expected 0 00001234 00000055",
                 k, bus3.rsp_valid, bus3.mul_a, bus3.mul_b);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (bus3.rsp_valid !== 1'b1) $display("FAIL lat3_valid: got %b expected 1", bus3.rsp_valid);
    else n_pass++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({bus3.rsp_id, bus3.rsp_data} !== {e.id, e.data})
        $display("FAIL lat3_rsp: got id %0d data %h expected id %0d data %h",
                 bus3.rsp_id, bus3.rsp_data, e.id, e.data);
      else n_pass++;
    end
    bus3.rsp_ready = 1'b1;
    tick();
    bus3.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [132:0] got;
    int           bad;
    do_reset();
    set_req(1, 3, 32'd5, 32'd6, 1'b1);
    tick();
    n_checks++;
    if (bus1.busy !== 1'b1) $display("FAIL rstmid_busy: got %b expected 1", bus1.busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    got = {bus1.busy, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_id, bus1.mul_a, bus1.mul_b,
           bus1.mul_carry_option};
    n_checks++;
    if (got !== '0) $display("FAIL rstmid_outputs: got %h expected 0", got);
    else n_pass++;
    n_checks++;
    if (bus1.req_ready !== 4'b1000)
      $display("FAIL rstmid_ready_a: got %b expected 1000", bus1.req_ready);
    else n_pass++;
    bus1.req_valid = 4'b1010;
    #1;
    n_checks++;
    if (bus1.req_ready !== 4'b0010)
      $display("FAIL rstmid_ready_b: got %b expected 0010", bus1.req_ready);
    else n_pass++;
    bus1.req_valid = '0;
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if ({bus1.rsp_valid, bus1.busy} !== 2'b00) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL rstmid_no_rsp: got %0d active cycles expected 0", bad);
    else n_pass++;
    for (int i = 0; i < NR; i++) set_req(1, i, 32'd1, 32'd1, 1'b1);
    #1;
    n_checks++;
    if (bus1.req_ready !== 4'b0001)
      $display("FAIL rstmid_next_grant: got %b expected 0001", bus1.req_ready);
    else n_pass++;
    bus1.req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_latency3();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
